// File: rtl/reg_bank_read4_if.sv
// Bus between the write-select decoder / operand-fetch stage and the
// four-entry register bank: write enables and data, read strobe and
// addresses, error clear, and the registered bank outputs.
interface reg_bank_read4_if #(
  parameter int unsigned WIDTH = 64
);
  logic [3:0]       wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic [1:0]       rd_addr_a;
  logic [1:0]       rd_addr_b;
  logic             err_clr;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid;
  logic [1:0]       wr_idx;
  logic             wr_idx_valid;
  logic             onehot_err;

  modport master (
    output wr_en, wr_data, rd_req, rd_addr_a, rd_addr_b, err_clr,
    input  rd_data_a, rd_data_b, rd_valid, wr_idx, wr_idx_valid, onehot_err
  );

  modport slave (
    input  wr_en, wr_data, rd_req, rd_addr_a, rd_addr_b, err_clr,
    output rd_data_a, rd_data_b, rd_valid, wr_idx, wr_idx_valid, onehot_err
  );
endinterface

// File: rtl/reg_bank_read4.sv
// Four-entry register bank fed by one-hot write enables. Legal writes are
// re-encoded into a registered binary index; two registered read ports
// bypass same-edge legal write data; multi-hot enables raise a sticky error.
module reg_bank_read4 #(
  parameter int unsigned WIDTH = 64
) (
  input logic            clk,
  input logic            reset_n,
  reg_bank_read4_if.slave bus
);

  logic [WIDTH-1:0] regs [4];

  logic             legal;
  logic             illegal;
  logic [1:0]       enc_idx;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // Classify the enable pattern, encode the one-hot index and form the
  // bypassed read values for both ports.
  always_comb begin
    legal   = 1'b0;
    illegal = 1'b0;
    enc_idx = '0;
    next_a  = '0;
    next_b  = '0;

    legal   = (bus.wr_en != '0) && ((bus.wr_en & (bus.wr_en - 4'd1)) == '0);
    illegal = (bus.wr_en != '0) && !legal;

    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.wr_en[i]) enc_idx = i[1:0];
    end

    next_a = (legal && (enc_idx == bus.rd_addr_a)) ? bus.wr_data : regs[bus.rd_addr_a];
    next_b = (legal && (enc_idx == bus.rd_addr_b)) ? bus.wr_data : regs[bus.rd_addr_b];
  end

  // Register storage: only legal one-hot writes update an entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (legal) begin
      regs[enc_idx] <= bus.wr_data;
    end
  end

  // Read ports: capture on a strobe, hold otherwise; rd_valid pulses per read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        bus.rd_data_a <= next_a;
        bus.rd_data_b <= next_b;
      end
    end
  end

  // Write index: updated only on legal writes, held across idle and illegal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_idx       <= '0;
      bus.wr_idx_valid <= 1'b0;
    end else begin
      bus.wr_idx_valid <= legal;
      if (legal) bus.wr_idx <= enc_idx;
    end
  end

  // Sticky error flag: an illegal pattern outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.onehot_err <= 1'b0;
    end else if (illegal) begin
      bus.onehot_err <= 1'b1;
    end else if (bus.err_clr) begin
      bus.onehot_err <= 1'b0;
    end
  end

endmodule

// File: doc/reg_bank_read4.md
# reg_bank_read4

Four-entry register bank that sits on the receiving end of the 2-to-4 write-select decoder. It consumes the decoder's one-hot write enables and re-encodes them into a registered 2-bit write index. It stores write data, serves two registered read ports with same-cycle write bypass, and flags any illegal (multi-hot) enable pattern. It sits between the write-select decoder and the operand-fetch stage of the pipeline.

## Interface
- WIDTH, 64, data width of each register and of all data ports
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  4  one-hot write enables from the write-select decoder; bit i selects register i
- wr_data  in  WIDTH  write data
- rd_req  in  1  read strobe; both read ports sampled when high
- rd_addr_a  in  2  read port A register index
- rd_addr_b  in  2  read port B register index
- err_clr  in  1  clears the sticky error flag
- rd_data_a  out  WIDTH  registered read data, port A
- rd_data_b  out  WIDTH  registered read data, port B
- rd_valid  out  1  one-cycle pulse; read data updated this cycle
- wr_idx  out  2  registered binary index of the last legal write
- wr_idx_valid  out  1  one-cycle pulse; a legal write completed at the last edge
- onehot_err  out  1  sticky; a multi-hot wr_en was seen

## Operation
- Storage: regs[0..3], each WIDTH bits.
- wr_en classification, evaluated each rising edge:
  - zero bits set: idle. No write; wr_idx_valid=0.
  - exactly one bit i set: legal write. regs[i] <= wr_data; wr_idx <= i; wr_idx_valid <= 1.
  - two or more bits set: illegal. No register is written; wr_idx holds; wr_idx_valid <= 0; onehot_err <= 1.
- Encoding is exact: 0001->0, 0010->1, 0100->2, 1000->3.
- Read: when rd_req=1 at an edge:
  - rd_data_a <= regs[rd_addr_a] and rd_data_b <= regs[rd_addr_b].
  - rd_valid <= 1.
- Read when rd_req=0: rd_data_a/b hold their previous value; rd_valid <= 0.
- Bypass: on a legal write to index i in the same edge as a read with rd_addr_x == i, port x captures wr_data, not the old regs[i]. The bypass applies to each port independently; both ports may bypass at once.
- Illegal writes never bypass.
- Error flag:
  - onehot_err sets on an illegal write and stays set until err_clr=1 at an edge.
  - If an illegal write and err_clr occur at the same edge, set wins (onehot_err=1).
- Port A and port B may address the same register; both return identical data.

## Timing
- Reset (reset_n=0, asynchronous, takes effect without a clock edge): all regs=0, rd_data_a=rd_data_b=0, rd_valid=0, wr_idx=0, wr_idx_valid=0, onehot_err=0.
- Outputs stay at these values while reset_n=0. The first edge with reset_n=1 is a normal operating edge.
- Reset asserted mid-operation discards any in-flight write or read; no partial update is visible.
- Write latency: one edge. Data written at edge N is readable by a read issued at edge N (bypass) or later.
- Read latency: one cycle. Request at edge N gives data and rd_valid=1 after edge N, held through edge N+1.
- Back-to-back reads are allowed every cycle; rd_valid stays high continuously.
- wr_idx_valid and rd_valid are single-cycle pulses per qualifying edge, with no handshake back-pressure.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset_n=0 mid-cycle with nonzero state -> all outputs 0 immediately. After release, read addr_a=0, addr_b=3 -> both ports return 0, rd_valid=1 for one cycle.
- Legal writes and encoding:
  - Stimulus: wr_en=0001/0010/0100/1000 with data 0x11/0x22/0x33/0x44 on consecutive edges.
  - Response: wr_idx=0,1,2,3, each with a wr_idx_valid pulse.
  - Then read A=2, B=1 -> 0x33 and 0x22.
- Bypass:
  - Stimulus: regs[1]=0xAA. At one edge, wr_en=0010 with wr_data=0xBB, and rd_req=1 with A=1, B=1.
  - Response: both ports=0xBB, rd_valid=1.
  - Next read of register 1 -> 0xBB.
- Illegal enable:
  - Stimulus: wr_en=0110 with wr_data=0xFF, and rd_req=1 with A=1, B=2.
  - Response: both ports return old values (no bypass), regs unchanged, onehot_err=1, wr_idx holds, wr_idx_valid=0.
- Error clear priority:
  - Stimulus: err_clr=1 with wr_en=0000 -> onehot_err=0.
  - Stimulus: err_clr=1 with wr_en=1111 at the same edge -> onehot_err stays 1.
- Hold behaviour: rd_req=0 for 3 cycles after a read -> rd_data_a/b unchanged, rd_valid=0. wr_en=0000 -> no register changes, wr_idx_valid=0.
